// File: rtl/multicycle_ctrl_fsm.sv
`default_nettype none
// multicycle_ctrl_fsm: main sequencer of a multicycle ARM-style datapath.
// Moore strobes/selects registered from next state; stall freezes state and masks write strobes.
module multicycle_ctrl_fsm (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  Op,
  input  logic [5:0]  Funct,
  input  logic        stall,
  output logic        IRWrite,
  output logic        NextPC,
  output logic        RegW,
  output logic        MemW,
  output logic        Branch,
  output logic        ALUOp,
  output logic        AdrSrc,
  output logic [1:0]  ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [1:0]  ResultSrc,
  output logic [3:0]  state,
  output logic        instr_done,
  output logic [15:0] instr_count,
  output logic        illegal
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMRD    = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWR    = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_UNKNOWN  = 4'd10
  } state_t;

  typedef struct packed {
    logic       ir_write;
    logic       next_pc;
    logic       reg_w;
    logic       mem_w;
    logic       branch;
    logic       alu_op;
    logic       adr_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] result_src;
    logic       illegal;
  } ctl_t;

  state_t      state_q;
  state_t      state_d;
  ctl_t        ctl_q;
  logic [15:0] instr_count_q;
  logic        bad_code;
  logic        retire;
  logic        unused_funct;

  function automatic ctl_t decode(input state_t s);
    ctl_t c;
    c = '0;
    case (s)
      S_FETCH: begin
        c.ir_write   = 1'b1;
        c.next_pc    = 1'b1;
        c.alu_src_a  = 2'b01;
        c.alu_src_b  = 2'b10;
        c.result_src = 2'b10;
      end
      S_DECODE: begin
        c.alu_src_a  = 2'b01;
        c.alu_src_b  = 2'b10;
        c.result_src = 2'b10;
      end
      S_MEMADR: begin
        c.alu_src_b  = 2'b01;
      end
      S_MEMRD: begin
        c.adr_src    = 1'b1;
      end
      S_MEMWB: begin
        c.result_src = 2'b01;
        c.reg_w      = 1'b1;
      end
      S_MEMWR: begin
        c.adr_src    = 1'b1;
        c.mem_w      = 1'b1;
      end
      S_EXECUTER: begin
        c.alu_op     = 1'b1;
      end
      S_EXECUTEI: begin
        c.alu_src_b  = 2'b01;
        c.alu_op     = 1'b1;
      end
      S_ALUWB: begin
        c.reg_w      = 1'b1;
      end
      S_BRANCH: begin
        c.alu_src_a  = 2'b10;
        c.alu_src_b  = 2'b01;
        c.result_src = 2'b10;
        c.branch     = 1'b1;
      end
      S_UNKNOWN: begin
        c.illegal    = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

  // Unused encodings escape to UNKNOWN even while stalled.
  assign bad_code = (state_q > S_UNKNOWN);

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        case (Op)
          2'b00:   state_d = Funct[5] ? S_EXECUTEI : S_EXECUTER;
          2'b01:   state_d = S_MEMADR;
          2'b10:   state_d = S_BRANCH;
          default: state_d = S_UNKNOWN;
        endcase
      end
      S_MEMADR:   state_d = Funct[0] ? S_MEMRD : S_MEMWR;
      S_MEMRD:    state_d = S_MEMWB;
      S_EXECUTER: state_d = S_ALUWB;
      S_EXECUTEI: state_d = S_ALUWB;
      S_MEMWB:    state_d = S_FETCH;
      S_MEMWR:    state_d = S_FETCH;
      S_ALUWB:    state_d = S_FETCH;
      S_BRANCH:   state_d = S_FETCH;
      S_UNKNOWN:  state_d = S_UNKNOWN;
      default:    state_d = S_UNKNOWN;
    endcase
    if (stall && !bad_code) begin
      state_d = state_q;
    end
  end

  assign retire = !stall && ((state_q == S_MEMWB) || (state_q == S_MEMWR) ||
                             (state_q == S_ALUWB) || (state_q == S_BRANCH));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_FETCH;
      ctl_q         <= decode(S_FETCH);
      instr_count_q <= 16'd0;
    end else begin
      state_q <= state_d;
      ctl_q   <= decode(state_d);
      if (retire) begin
        instr_count_q <= instr_count_q + 16'd1;
      end
    end
  end

  assign IRWrite     = ctl_q.ir_write & ~stall;
  assign NextPC      = ctl_q.next_pc  & ~stall;
  assign RegW        = ctl_q.reg_w    & ~stall;
  assign MemW        = ctl_q.mem_w    & ~stall;
  assign Branch      = ctl_q.branch   & ~stall;
  assign ALUOp       = ctl_q.alu_op;
  assign AdrSrc      = ctl_q.adr_src;
  assign ALUSrcA     = ctl_q.alu_src_a;
  assign ALUSrcB     = ctl_q.alu_src_b;
  assign ResultSrc   = ctl_q.result_src;
  assign illegal     = ctl_q.illegal;
  assign state       = state_q;
  assign instr_done  = retire;
  assign instr_count = instr_count_q;

  assign unused_funct = ^Funct[4:1];

endmodule
`default_nettype wire

// File: tb/tb_multicycle_ctrl_fsm.sv
`default_nettype none
// tb_multicycle_ctrl_fsm: directed and randomized checks of the controller
// against a per-instruction state-path model.
module tb_multicycle_ctrl_fsm;

  logic        clk;
  logic        reset;
  logic [1:0]  Op;
  logic [5:0]  Funct;
  logic        stall;
  logic        IRWrite, NextPC, RegW, MemW, Branch, ALUOp, AdrSrc;
  logic [1:0]  ALUSrcA, ALUSrcB, ResultSrc;
  logic [3:0]  state;
  logic        instr_done;
  logic [15:0] instr_count;
  logic        illegal;

  multicycle_ctrl_fsm dut (
    .clk(clk), .reset(reset), .Op(Op), .Funct(Funct), .stall(stall),
    .IRWrite(IRWrite), .NextPC(NextPC), .RegW(RegW), .MemW(MemW),
    .Branch(Branch), .ALUOp(ALUOp), .AdrSrc(AdrSrc),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc),
    .state(state), .instr_done(instr_done), .instr_count(instr_count),
    .illegal(illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;

  // {IRWrite,NextPC,RegW,MemW,Branch,ALUOp,AdrSrc,ALUSrcA,ALUSrcB,ResultSrc}
  logic [12:0] want_tab [0:10];
  int          exp_state;
  int          exp_cnt;
  int          plan [$];
  logic [1:0]  cur_op;
  logic [5:0]  cur_fn;
  int          n_regw, n_memw, n_br, n_done;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_total++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got=%0h want=%0h (t=%0t)", tag, got, want, $time);
    end
  endtask

  task automatic check_outputs(input logic st);
    logic [12:0] obs;
    logic [12:0] exp_ctl;
    logic        exp_done;
    obs = {IRWrite, NextPC, RegW, MemW, Branch, ALUOp, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc};
    exp_ctl = want_tab[exp_state];
    if (st) exp_ctl = exp_ctl & 13'h0FF;
    exp_done = !st && (exp_state inside {4, 5, 8, 9});
    check_eq("state",   32'(state), 32'(exp_state));
    check_eq("ctl",     32'(obs), 32'(exp_ctl));
    check_eq("done",    32'(instr_done), 32'(exp_done));
    check_eq("count",   32'(instr_count), 32'(exp_cnt));
    check_eq("illegal", 32'(illegal), 32'(exp_state == 10));
  endtask

  // One clock: drive, check at negedge, advance model on posedge.
  task automatic cycle(input logic st);
    if (exp_state == 1 || exp_state == 2) begin
      Op = cur_op; Funct = cur_fn;
    end else begin
      Op = 2'($urandom); Funct = 6'($urandom);
    end
    stall = st;
    @(negedge clk);
    check_outputs(st);
    if (RegW) n_regw++;
    if (MemW) n_memw++;
    if (Branch) n_br++;
    if (instr_done) n_done++;
    @(posedge clk);
    if (!st) begin
      if (exp_state inside {4, 5, 8, 9}) exp_cnt = (exp_cnt + 1) & 32'hFFFF;
      if (exp_state != 10 && plan.size() != 0) exp_state = plan.pop_front();
    end
    #1;
  endtask

  task automatic start_instr(input logic [1:0] op, input logic [5:0] fn);
    cur_op = op; cur_fn = fn;
    plan.delete();
    case (op)
      2'b01:   plan = fn[0] ? '{1, 2, 3, 4, 0} : '{1, 2, 5, 0};
      2'b00:   plan = fn[5] ? '{1, 7, 8, 0} : '{1, 6, 8, 0};
      2'b10:   plan = '{1, 9, 0};
      default: plan = '{1, 10};
    endcase
  endtask

  function automatic int base_latency(input logic [1:0] op, input logic [5:0] fn);
    if (op == 2'b01) return fn[0] ? 5 : 4;
    if (op == 2'b00) return 4;
    return 3;
  endfunction

  task automatic run_instr(input logic [1:0] op, input logic [5:0] fn,
                           input int stall_state, input int stall_n, input int rnd_pct);
    int   cyc, stalls, lat, forced;
    logic st, left;
    cyc = 0; stalls = 0; lat = -1; forced = 0; left = 1'b0;
    n_regw = 0; n_memw = 0; n_br = 0; n_done = 0;
    start_instr(op, fn);
    while (plan.size() != 0) begin
      st = 1'b0;
      if (exp_state == stall_state && forced < stall_n) begin
        st = 1'b1; forced++;
      end else if (rnd_pct > 0 && $urandom_range(99) < rnd_pct) begin
        st = 1'b1;
      end
      if (st) stalls++;
      cycle(st);
      cyc++;
      if (state != 4'd0) left = 1'b1;
      else if (left && lat < 0) lat = cyc;
    end
    if (op != 2'b11) check_eq("latency", 32'(lat), 32'(base_latency(op, fn) + stalls));
  endtask

  task automatic async_reset();
    stall = 1'b0;
    #2 reset = 1'b1;
    #1;
    check_eq("arst_state", 32'(state), 32'd0);
    check_eq("arst_cnt",   32'(instr_count), 32'd0);
    check_eq("arst_ill",   32'(illegal), 32'd0);
    check_eq("arst_done",  32'(instr_done), 32'd0);
    check_eq("arst_irw",   32'(IRWrite), 32'd1);
    @(posedge clk); #1;
    reset = 1'b0;
    exp_state = 0; exp_cnt = 0; plan.delete();
  endtask

  initial begin
    want_tab[0]  = 13'b1100000_01_10_10;
    want_tab[1]  = 13'b0000000_01_10_10;
    want_tab[2]  = 13'b0000000_00_01_00;
    want_tab[3]  = 13'b0000001_00_00_00;
    want_tab[4]  = 13'b0010000_00_00_01;
    want_tab[5]  = 13'b0001001_00_00_00;
    want_tab[6]  = 13'b0000010_00_00_00;
    want_tab[7]  = 13'b0000010_00_01_00;
    want_tab[8]  = 13'b0010000_00_00_00;
    want_tab[9]  = 13'b0000100_10_01_10;
    want_tab[10] = 13'b0000000_00_00_00;

    reset = 1'b1; stall = 1'b0; Op = 2'b00; Funct = 6'd0;
    exp_state = 0; exp_cnt = 0;
    @(negedge clk);
    check_eq("rst_state", 32'(state), 32'd0);
    check_eq("rst_cnt",   32'(instr_count), 32'd0);
    check_eq("rst_irw",   32'(IRWrite), 32'd1);
    check_eq("rst_npc",   32'(NextPC), 32'd1);
    check_eq("rst_done",  32'(instr_done), 32'd0);
    stall = 1'b1;
    #1;
    check_eq("rst_stall_irw", 32'(IRWrite), 32'd0);
    check_eq("rst_stall_npc", 32'(NextPC), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0; stall = 1'b0;

    run_instr(2'b00, 6'b101000, -1, 0, 0);
    check_eq("dpi_count", 32'(instr_count), 32'd1);
    check_eq("dpi_regw",  32'(n_regw), 32'd1);

    run_instr(2'b01, 6'b000001, -1, 0, 0);
    check_eq("ldr_regw", 32'(n_regw), 32'd1);

    run_instr(2'b01, 6'b110110, -1, 0, 0);
    check_eq("str_memw", 32'(n_memw), 32'd1);

    run_instr(2'b10, 6'b000000, -1, 0, 0);
    check_eq("b_branch", 32'(n_br), 32'd1);

    run_instr(2'b00, 6'b011111, -1, 0, 0);
    check_eq("dpr_count", 32'(instr_count), 32'd5);

    run_instr(2'b01, 6'b100001, 4, 3, 0);
    check_eq("stall_regw", 32'(n_regw), 32'd1);
    check_eq("stall_done", 32'(n_done), 32'd1);

    for (int i = 0; i < 150; i++) begin
      run_instr(2'($urandom_range(2)), 6'($urandom), -1, 0, 20);
    end

    // Preload the retired count just below wrap.
    force dut.instr_count_q = 16'hFFFF;
    #1;
    release dut.instr_count_q;
    exp_cnt = 32'hFFFF;
    run_instr(2'b10, 6'b000000, -1, 0, 0);
    check_eq("wrap_count", 32'(instr_count), 32'd0);

    run_instr(2'b00, 6'b000000, -1, 0, 0);
    start_instr(2'b00, 6'b000000);
    cycle(1'b0);
    cycle(1'b0);
    check_eq("in_executer", 32'(state), 32'd6);
    async_reset();

    run_instr(2'b11, 6'($urandom), -1, 0, 0);
    for (int i = 0; i < 22; i++) begin
      cycle(1'($urandom_range(1)));
    end
    check_eq("unk_state", 32'(state), 32'd10);
    async_reset();

    run_instr(2'b01, 6'b000001, -1, 0, 0);
    check_eq("recover_count", 32'(instr_count), 32'd1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
